// File: rtl/exec_datapath_unit.sv
// Execution datapath for the 16-bit processor.
// Contains an 8-entry register file, the ALU and a shift-add multiplier that steps once per cycle.
module exec_datapath_unit #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 8,
  parameter int MUL_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        opcode,
  input  logic [2:0]        rreg1,
  input  logic [2:0]        rreg2,
  input  logic [2:0]        wreg,
  input  logic [5:0]        imm,
  input  logic              src2_sel,
  input  logic              alu_out_sel,
  input  logic              reg_write,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              branch_taken,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int CW = $clog2(MUL_CYC);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
    OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SLT = 4'd7, OP_MUL = 4'd8, OP_BEQ = 4'd9
  } op_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd_a, op_b, imm_ext, alu_val, wb_val;
  logic              accept;

  logic [DATA_W-1:0] mul_acc, mul_cand, mul_plier, mul_imm, mul_sum, mul_wb;
  logic [CW-1:0]     mul_cnt;
  logic [2:0]        mul_wreg;
  logic              mul_we, mul_imm_sel, mul_last;

  // R0 is reset to zero and never written, so it always reads zero
  assign rd_a     = regs[rreg1];
  assign imm_ext  = {{(DATA_W-6){imm[5]}}, imm};
  assign op_b     = src2_sel ? imm_ext : regs[rreg2];
  assign dbg_data = regs[dbg_addr];
  assign accept   = issue_valid & issue_ready;

  always_comb begin
    alu_val = '0;
    case (opcode)
      OP_ADD:         alu_val = rd_a + op_b;
      OP_SUB, OP_BEQ: alu_val = rd_a - op_b;
      OP_AND:         alu_val = rd_a & op_b;
      OP_OR:          alu_val = rd_a | op_b;
      OP_XOR:         alu_val = rd_a ^ op_b;
      OP_SLL:         alu_val = rd_a << op_b[3:0];
      OP_SRL:         alu_val = rd_a >> op_b[3:0];
      OP_SLT:         alu_val = {{(DATA_W-1){1'b0}}, $signed(rd_a) < $signed(op_b)};
      default:        alu_val = '0;
    endcase
    wb_val = alu_out_sel ? imm_ext : alu_val;
  end

  assign mul_sum  = mul_plier[0] ? mul_acc + mul_cand : mul_acc;
  assign mul_wb   = mul_imm_sel ? mul_imm : mul_sum;
  assign mul_last = (mul_cnt == CW'(MUL_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    issue_ready = 1'b0;
    case (state)
      S_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid && opcode == OP_MUL) state_next = S_MUL;
      end
      S_MUL:   if (mul_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      zero_flag    <= 1'b1;
      branch_taken <= 1'b0;
      mul_acc      <= '0;
      mul_cand     <= '0;
      mul_plier    <= '0;
      mul_imm      <= '0;
      mul_cnt      <= '0;
      mul_wreg     <= '0;
      mul_we       <= 1'b0;
      mul_imm_sel  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      branch_taken <= 1'b0;
      if (accept) begin
        case (opcode)
          OP_MUL: begin
            mul_acc     <= '0;
            mul_cand    <= rd_a;
            mul_plier   <= op_b;
            mul_imm     <= imm_ext;
            mul_cnt     <= '0;
            mul_wreg    <= wreg;
            mul_we      <= reg_write;
            mul_imm_sel <= alu_out_sel;
          end
          OP_BEQ: begin
            result_valid <= 1'b1;
            result       <= alu_val;
            zero_flag    <= (alu_val == '0);
            branch_taken <= (rd_a == op_b);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT: begin
            result_valid <= 1'b1;
            result       <= wb_val;
            zero_flag    <= (wb_val == '0);
            if (reg_write && wreg != 3'd0) regs[wreg] <= wb_val;
          end
          default: result_valid <= 1'b1;
        endcase
      end else if (state == S_MUL) begin
        mul_acc   <= mul_sum;
        mul_cand  <= mul_cand << 1;
        mul_plier <= mul_plier >> 1;
        mul_cnt   <= mul_cnt + 1'b1;
        if (mul_last) begin
          result_valid <= 1'b1;
          result       <= mul_wb;
          zero_flag    <= (mul_wb == '0);
          if (mul_we && mul_wreg != 3'd0) regs[mul_wreg] <= mul_wb;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_datapath_unit.sv
// Self-checking bench for exec_datapath_unit: directed scenarios plus random
// instructions compared against an architectural register/result model.
module tb_exec_datapath_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  opcode = '0;
  logic [2:0]  rreg1 = '0, rreg2 = '0, wreg = '0, dbg_addr = '0;
  logic [5:0]  imm = '0;
  logic        src2_sel = 1'b0, alu_out_sel = 1'b0, reg_write = 1'b0;
  logic        result_valid, zero_flag, branch_taken;
  logic [15:0] result, dbg_data;

  int passed = 0;
  int total  = 0;

  logic [15:0] mr [8];
  logic [15:0] exp_result;
  logic        exp_zero, exp_branch;

  always #5 clk = ~clk;

  exec_datapath_unit #(.DATA_W(16), .NREGS(8), .MUL_CYC(16)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .rreg1(rreg1), .rreg2(rreg2), .wreg(wreg), .imm(imm),
    .src2_sel(src2_sel), .alu_out_sel(alu_out_sel), .reg_write(reg_write),
    .result_valid(result_valid), .result(result), .zero_flag(zero_flag),
    .branch_taken(branch_taken), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mr[i] = '0;
    exp_result = '0;
    exp_zero   = 1'b1;
    exp_branch = 1'b0;
  endtask

  // Architectural effect of one instruction, computed from the ISA rules.
  task automatic model_exec(input int op, input int r1, input int r2, input int w,
                            input logic [5:0] im, input logic s2, input logic aos,
                            input logic we);
    logic [15:0] a, b, v, sx;
    int unsigned p;
    sx = 16'($signed(im));
    a  = mr[r1];
    b  = s2 ? sx : mr[r2];
    p  = 32'(a) * 32'(b);
    case (op)
      0: v = a + b;
      1: v = a - b;
      2: v = a & b;
      3: v = a | b;
      4: v = a ^ b;
      5: v = a << (b % 16);
      6: v = a >> (b % 16);
      7: v = (shortint'(a) < shortint'(b)) ? 16'd1 : 16'd0;
      8: v = 16'(p % 65536);
      default: v = a - b;
    endcase
    exp_branch = 1'b0;
    if (op == 9) begin
      exp_result = v;
      exp_zero   = (v == 0);
      exp_branch = (a == b);
    end else if (op <= 8) begin
      if (aos) v = sx;
      exp_result = v;
      exp_zero   = (v == 0);
      if (we && w != 0) mr[w] = v;
    end
  endtask

  // Waits (bounded) for issue_ready, presents one instruction for one edge.
  task automatic issue(input int op, input int r1, input int r2, input int w,
                       input logic [5:0] im, input logic s2, input logic aos,
                       input logic we);
    int n = 0;
    while (issue_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n == 50) begin
      total++;
      $display("FAIL issue_wait: issue_ready=%b required 1 within 50 cycles", issue_ready);
    end
    model_exec(op, r1, r2, w, im, s2, aos, we);
    opcode = 4'(op); rreg1 = 3'(r1); rreg2 = 3'(r2); wreg = 3'(w);
    imm = im; src2_sel = s2; alu_out_sel = aos; reg_write = we;
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    total++; if (issue_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", issue_ready); else passed++;
    total++; if (result !== 16'h0) $display("FAIL reset_result: got %h want 0000", result); else passed++;
    total++; if (zero_flag !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero_flag); else passed++;
    total++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", result_valid); else passed++;
    total++; if (branch_taken !== 1'b0) $display("FAIL reset_branch: got %b want 0", branch_taken); else passed++;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      total++;
      if (dbg_data !== 16'h0) $display("FAIL reset_reg%0d: got %h want 0000", i, dbg_data); else passed++;
    end
  endtask

  task automatic test_add_back_to_back();
    issue(0, 0, 0, 1, 6'd5, 1'b1, 1'b0, 1'b1);
    total++; if (result_valid !== 1'b1 || result !== 16'd5)
      $display("FAIL add_imm: valid=%b result=%h want 1/0005", result_valid, result); else passed++;
    issue(0, 1, 1, 2, 6'd0, 1'b0, 1'b0, 1'b1);
    total++; if (result_valid !== 1'b1 || result !== 16'd10)
      $display("FAIL add_b2b: valid=%b result=%h want 1/000a", result_valid, result); else passed++;
    step();
    total++; if (result_valid !== 1'b0) $display("FAIL add_pulse: valid=%b want 0", result_valid); else passed++;
    dbg_addr = 3'd1; #1;
    total++; if (dbg_data !== 16'd5) $display("FAIL add_r1: got %h want 0005", dbg_data); else passed++;
    dbg_addr = 3'd2; #1;
    total++; if (dbg_data !== 16'd10) $display("FAIL add_r2: got %h want 000a", dbg_data); else passed++;
  endtask

  task automatic test_sub_slt();
    issue(0, 0, 0, 1, 6'h3F, 1'b1, 1'b1, 1'b1);   // R1 = sext(-1) = FFFF
    issue(6, 1, 0, 1, 6'd1, 1'b1, 1'b0, 1'b1);    // R1 = FFFF >> 1 = 7FFF
    total++; if (result !== 16'h7FFF) $display("FAIL srl_r1: got %h want 7fff", result); else passed++;
    issue(1, 0, 1, 3, 6'd0, 1'b0, 1'b0, 1'b1);
    total++; if (result !== 16'h8001 || zero_flag !== 1'b0)
      $display("FAIL sub_r3: result=%h zero=%b want 8001/0", result, zero_flag); else passed++;
    issue(7, 3, 1, 4, 6'd0, 1'b0, 1'b0, 1'b1);
    total++; if (result !== 16'h0001) $display("FAIL slt_r4: got %h want 0001", result); else passed++;
    dbg_addr = 3'd4; #1;
    total++; if (dbg_data !== 16'h0001) $display("FAIL slt_reg: got %h want 0001", dbg_data); else passed++;
  endtask

  task automatic test_mul();
    int k = 0;
    int low = 0;
    issue(0, 0, 0, 1, 6'd19, 1'b1, 1'b0, 1'b1);   // 19
    issue(5, 1, 0, 1, 6'd4, 1'b1, 1'b0, 1'b1);    // 304
    issue(1, 1, 0, 1, 6'd4, 1'b1, 1'b0, 1'b1);    // 300
    issue(0, 1, 0, 2, 6'd0, 1'b0, 1'b0, 1'b1);    // R2 = 300
    issue(8, 1, 2, 5, 6'd0, 1'b0, 1'b0, 1'b1);
    while (result_valid !== 1'b1 && k < 40) begin
      if (issue_ready === 1'b0) low++;
      step();
      k++;
    end
    total++; if (k !== 16) $display("FAIL mul_latency: edges after accept=%0d want 16", k); else passed++;
    total++; if (low !== 16) $display("FAIL mul_ready_low: cycles=%0d want 16", low); else passed++;
    total++; if (issue_ready !== 1'b1) $display("FAIL mul_ready_back: got %b want 1", issue_ready); else passed++;
    total++; if (result !== 16'h5F90 || zero_flag !== 1'b0)
      $display("FAIL mul_result: result=%h zero=%b want 5f90/0", result, zero_flag); else passed++;
    dbg_addr = 3'd5; #1;
    total++; if (dbg_data !== 16'h5F90) $display("FAIL mul_r5: got %h want 5f90", dbg_data); else passed++;
  endtask

  task automatic test_beq_nop();
    issue(9, 1, 1, 6, 6'd0, 1'b0, 1'b0, 1'b1);
    total++; if (branch_taken !== 1'b1 || zero_flag !== 1'b1 || result !== 16'h0)
      $display("FAIL beq_eq: br=%b zero=%b result=%h want 1/1/0000", branch_taken, zero_flag, result); else passed++;
    dbg_addr = 3'd6; #1;
    total++; if (dbg_data !== 16'h0) $display("FAIL beq_nowrite: got %h want 0000", dbg_data); else passed++;
    issue(9, 1, 2, 6, 6'd0, 1'b1, 1'b0, 1'b1);    // 300 vs sext(0)
    total++; if (branch_taken !== 1'b0 || result !== 16'd300)
      $display("FAIL beq_ne: br=%b result=%h want 0/012c", branch_taken, result); else passed++;
    step();
    total++; if (branch_taken !== 1'b0) $display("FAIL beq_pulse: got %b want 0", branch_taken); else passed++;
    issue(12, 1, 2, 6, 6'd9, 1'b1, 1'b1, 1'b1);
    total++; if (result_valid !== 1'b1 || result !== 16'd300)
      $display("FAIL nop: valid=%b result=%h want 1/012c", result_valid, result); else passed++;
    dbg_addr = 3'd6; #1;
    total++; if (dbg_data !== 16'h0) $display("FAIL nop_nowrite: got %h want 0000", dbg_data); else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int op, k;
      op = ($urandom_range(0, 5) == 0) ? 8 : int'($urandom_range(0, 15));
      issue(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            6'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom));
      k = 0;
      while (result_valid !== 1'b1 && k < 40) begin
        step();
        k++;
      end
      total++;
      if (k !== (op == 8 ? 16 : 0) || result !== exp_result || zero_flag !== exp_zero
          || branch_taken !== exp_branch)
        $display("FAIL rand%0d op%0d: lat=%0d res=%h z=%b br=%b want lat=%0d res=%h z=%b br=%b",
                 it, op, k, result, zero_flag, branch_taken, (op == 8 ? 16 : 0),
                 exp_result, exp_zero, exp_branch);
      else passed++;
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      total++;
      if (dbg_data !== mr[i]) $display("FAIL rand_reg%0d: got %h want %h", i, dbg_data, mr[i]); else passed++;
    end
  endtask

  task automatic test_mul_reset();
    int seen = 0;
    issue(0, 0, 0, 1, 6'd7, 1'b1, 1'b0, 1'b1);
    issue(8, 1, 1, 6, 6'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    total++; if (issue_ready !== 1'b1 || result_valid !== 1'b0)
      $display("FAIL mulrst_state: ready=%b valid=%b want 1/0", issue_ready, result_valid); else passed++;
    for (int i = 0; i < 20; i++) begin
      if (result_valid === 1'b1) seen++;
      step();
    end
    total++; if (seen !== 0) $display("FAIL mulrst_novalid: pulses=%0d want 0", seen); else passed++;
    dbg_addr = 3'd6; #1;
    total++; if (dbg_data !== 16'h0) $display("FAIL mulrst_r6: got %h want 0000", dbg_data); else passed++;
    issue(0, 0, 0, 0, 6'd7, 1'b1, 1'b0, 1'b1);
    dbg_addr = 3'd0; #1;
    total++; if (dbg_data !== 16'h0 || result !== 16'd7)
      $display("FAIL r0_write: r0=%h result=%h want 0000/0007", dbg_data, result); else passed++;
  endtask

  initial begin
    test_reset();
    test_add_back_to_back();
    test_sub_slt();
    test_mul();
    test_beq_nop();
    test_random();
    test_mul_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
